if_fetch_queue: RTL and testbench

- Consumer end of the fetch-stage PC register: takes the fetch address stream (pcF, pc_plus4F), issues in-order requests to a variable-latency instruction memory and buffers the returned words.
- Presents {instr, pc, pc_plus4} to decode with a valid/ready handshake.
- Drops all wrong-path fetches on an execute-stage redirect (flush).
- Its pc_ready output drives the PC register's enable.

---
 rtl/if_fetch_queue_pkg.sv | 19 +
 rtl/if_fetch_queue.sv | 115 +++++++++++
 tb/tb_if_fetch_queue.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-pipeline types: per-slot state of the fetch queue and the
// {instr, pc, pc_plus4} bundle handed from IF to the IF/ID register.
package if_fetch_queue_pkg;

    localparam int IF_XLEN = 32;

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_READY   = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic [IF_XLEN-1:0] instr;
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Fetch queue between the PC register and decode: issues in-order imem
// requests, buffers returned words and kills wrong-path fetches on flush.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DATA_WIDTH = IF_XLEN,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] pc_plus4_in,
    input  logic                  pc_valid,
    output logic                  pc_ready,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid_d,
    input  logic                  instr_ready_d,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    slot_state_e                       state_q [DEPTH];
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  pc_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  pc4_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  instr_q;

    logic [PTR_W-1:0] wr_ptr, fill_ptr, rd_ptr;
    logic [CNT_W-1:0] discard_q;

    logic [CNT_W-1:0] occ, n_pend;
    logic [CNT_W:0]   budget;
    logic             accept, rsp_drop, rsp_fill, pop, rsp_dec;
    logic [CNT_W-1:0] discard_flush;

    always_comb begin
        occ    = '0;
        n_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] != SLOT_EMPTY)   occ    = occ + CNT_W'(1);
            if (state_q[i] == SLOT_PENDING) n_pend = n_pend + CNT_W'(1);
        end
    end

    // In-flight discards still occupy memory bandwidth, so they count
    // against the same budget as live slots.
    assign budget   = {1'b0, occ} + {1'b0, discard_q};
    assign imem_req = !rst && pc_valid && !flush && (budget < (CNT_W+1)'(DEPTH));
    assign imem_addr = pc_in;
    assign pc_ready  = imem_req && imem_gnt;
    assign accept    = pc_ready;

    assign rsp_drop = imem_rvalid && (discard_q != '0);
    assign rsp_fill = imem_rvalid && (discard_q == '0) && (state_q[fill_ptr] == SLOT_PENDING);

    assign instr_valid_d = (state_q[rd_ptr] == SLOT_READY);
    assign pop           = instr_valid_d && instr_ready_d;

    assign instr_d    = instr_valid_d ? instr_q[rd_ptr] : '0;
    assign pc_d       = instr_valid_d ? pc_q[rd_ptr]    : '0;
    assign pc_plus4_d = instr_valid_d ? pc4_q[rd_ptr]   : '0;

    // On flush every outstanding response becomes a discard, except one
    // arriving this very cycle, which is simply dropped.
    assign rsp_dec       = imem_rvalid && ((discard_q != '0) || (n_pend != '0));
    assign discard_flush = discard_q + n_pend - CNT_W'(rsp_dec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= SLOT_EMPTY;
            wr_ptr    <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            discard_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= SLOT_EMPTY;
            wr_ptr    <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            discard_q <= discard_flush;
        end else begin
            if (accept) begin
                state_q[wr_ptr] <= SLOT_PENDING;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (rsp_drop) discard_q <= discard_q - CNT_W'(1);
            if (rsp_fill) begin
                state_q[fill_ptr] <= SLOT_READY;
                fill_ptr          <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
                state_q[rd_ptr] <= SLOT_EMPTY;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Payload needs no reset: it is only visible behind a READY slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q[wr_ptr]  <= pc_in;
            pc4_q[wr_ptr] <= pc_plus4_in;
        end
        if (rsp_fill && !flush) instr_q[fill_ptr] <= imem_rdata;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized scoreboard bench for if_fetch_queue with a queue-level memory
// and decode model.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, pc_valid = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic        instr_ready_d = 1'b0;
    logic [31:0] pc_in = '0, pc_plus4_in = '0, imem_rdata = '0;
    logic        pc_ready, imem_req, instr_valid_d;
    logic [31:0] imem_addr, instr_d, pc_d, pc_plus4_d;

    if_fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .pc_in(pc_in), .pc_plus4_in(pc_plus4_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid_d(instr_valid_d), .instr_ready_d(instr_ready_d),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] pc4; logic [31:0] instr; } exp_t;

    mreq_t memq[$];
    exp_t  expq[$];

    int total = 0, bad = 0, cyc = 0;
    int buffered = 0;
    int dut_grants = 0, dut_pops = 0;
    bit flush_prev = 1'b0, in_reset = 1'b1;
    logic [31:0] pc = 32'h0BFC0000;

    int k_valid = 0, k_gnt = 1, k_ready = 1, k_lat_lo = 1, k_lat_hi = 1, k_flush_pct = 0;
    bit k_tgt_fixed = 1'b0, gnt_tog = 1'b0;
    logic [31:0] k_tgt = 32'h100;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        if (a[31:16] == 16'h0BFC) return 32'h00000013;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // mode: 0 never, 1 always, 2 random (mostly high)
    function automatic bit pick(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(3) != 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cycle(input bit force_flush);
        mreq_t r;
        bit    exp_req, rsp_live, popped;
        int    lat;
        @(negedge clk);
        cyc++;
        flush    = force_flush || ($urandom_range(99) < k_flush_pct);
        pc_valid = pick(k_valid);
        if (k_gnt == 3) begin
            gnt_tog  = ~gnt_tog;
            imem_gnt = gnt_tog;
        end else begin
            imem_gnt = pick(k_gnt);
        end
        instr_ready_d = pick(k_ready);
        pc_in       = pc;
        pc_plus4_in = pc + 32'd4;
        exp_req = pc_valid && !flush && (memq.size() + buffered < DEPTH);
        rsp_live = 1'b0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            r = memq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(r.addr);
            rsp_live    = !r.stale;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        chk("imem_req", imem_req, exp_req);
        chk("pc_ready", pc_ready, exp_req && imem_gnt);
        if (imem_req) chk("imem_addr", imem_addr, pc);
        if (pc_ready) dut_grants++;
        if (exp_req && imem_gnt) begin
            lat = $urandom_range(k_lat_hi, k_lat_lo);
            memq.push_back('{addr: pc, due: cyc + lat, stale: 1'b0});
            expq.push_back('{pc: pc, pc4: pc + 32'd4, instr: mem_word(pc)});
            pc = pc + 32'd4;
        end
        #2;
        popped = (buffered > 0) && instr_ready_d;
        if (rsp_live && !flush) buffered++;
        if (popped) buffered--;
        if (flush) begin
            buffered = 0;
            foreach (memq[i]) memq[i].stale = 1'b1;
            expq.delete();
            pc = k_tgt_fixed ? k_tgt : {14'd0, 16'($urandom), 2'b00};
        end
        flush_prev = flush;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_reset = 1'b1;
        #1;
        rst = 1'b1;
        pc_valid = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; instr_ready_d = 1'b1; flush = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc_ready", pc_ready, 0);
        chk("rst_valid", instr_valid_d, 0);
        chk("rst_pc_d", pc_d, 0);
        chk("rst_pc_plus4_d", pc_plus4_d, 0);
        chk("rst_instr_d", instr_d, 0);
        memq.delete();
        expq.delete();
        buffered = 0;
        flush_prev = 1'b0;
        pc = 32'h0BFC0000;
        repeat (2) @(negedge clk);
        pc_valid = 1'b0; imem_gnt = 1'b0; instr_ready_d = 1'b0;
        rst = 1'b0;
        in_reset = 1'b0;
    endtask

    task automatic set_knobs(input int v, input int g, input int rd, input int lo, input int hi, input int fp);
        k_valid = v; k_gnt = g; k_ready = rd; k_lat_lo = lo; k_lat_hi = hi; k_flush_pct = fp;
    endtask

    // Decode-side monitor: pops the scoreboard whenever the DUT hands over an entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!in_reset) begin
                chk("instr_valid_d", instr_valid_d, buffered > 0);
                if (flush_prev) chk("valid_after_flush", instr_valid_d, 0);
                if (instr_valid_d && instr_ready_d) begin
                    dut_pops++;
                    if (expq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_pop: got pc %h want none (cycle %0d)", pc_d, cyc);
                    end else begin
                        e = expq.pop_front();
                        chk("pc_d", pc_d, e.pc);
                        chk("pc_plus4_d", pc_plus4_d, e.pc4);
                        chk("instr_d", instr_d, e.instr);
                    end
                end else if (!instr_valid_d) begin
                    chk("idle_pc_d", pc_d, 0);
                    chk("idle_instr_d", instr_d, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, p0;
        do_reset();

        // Steady stream: one grant and, after startup, one pop per cycle
        set_knobs(1, 1, 1, 1, 1, 0);
        p0 = dut_pops;
        run(20);
        chk("stream_pops", dut_pops - p0, 18);

        // Backpressure fills exactly DEPTH slots; one pop frees one
        set_knobs(0, 1, 1, 1, 1, 0);
        run(8);
        set_knobs(1, 1, 0, 1, 1, 0);
        g0 = dut_grants;
        run(10);
        chk("full_grants", dut_grants - g0, DEPTH);
        set_knobs(1, 1, 1, 1, 1, 0);
        g0 = dut_grants; p0 = dut_pops;
        run(1);
        chk("full_pop", dut_pops - p0, 1);
        set_knobs(1, 1, 0, 1, 1, 0);
        run(5);
        chk("refill_grants", dut_grants - g0, 1);

        // Three long-latency fetches killed by flush, then a fresh one at 0x100
        set_knobs(0, 1, 1, 1, 1, 0);
        run(8);
        set_knobs(1, 1, 1, 5, 5, 0);
        run(3);
        k_tgt_fixed = 1'b1; k_tgt = 32'h100;
        cycle(1'b1);
        set_knobs(1, 1, 1, 1, 1, 0);
        g0 = dut_grants;
        run(1);
        chk("post_flush_grant", dut_grants - g0, 1);
        set_knobs(0, 1, 1, 1, 1, 0);
        p0 = dut_pops;
        run(15);
        chk("post_flush_pops", dut_pops - p0, 1);

        // Flush colliding with a response and a pop in a pipelined stream
        k_tgt = 32'h0BFC0800;
        set_knobs(1, 1, 1, 2, 2, 0);
        run(6);
        cycle(1'b1);
        run(8);
        k_tgt_fixed = 1'b0;

        // Random traffic, toggling grant
        set_knobs(2, 3, 2, 1, 4, 4);
        run(400);

        // Reset with two pending and one ready entry
        set_knobs(0, 1, 1, 1, 1, 0);
        run(8);
        set_knobs(1, 1, 0, 2, 2, 0);
        run(3);
        do_reset();

        set_knobs(2, 2, 2, 1, 4, 3);
        run(300);
        set_knobs(0, 1, 1, 1, 1, 0);
        run(20);
        chk("drained_valid", instr_valid_d, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
